// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: default widths, the NOP encoding,
// jump-target field positions and the pc source selector.
package pc_fetch_unit_pkg;

    localparam int PC_W    = 13;
    localparam int INSTR_W = 14;
    localparam int STACK_D = 8;

    localparam logic [PC_W-1:0]    RESET_PC = 13'h0000;
    localparam logic [INSTR_W-1:0] ISA_NOP  = 14'h0000;

    // goto/call carry an 11-bit target; PCLATH supplies the two page bits above it
    localparam int JMP_FIELD_MSB = 10;
    localparam int JMP_PAGE_MSB  = 4;
    localparam int JMP_PAGE_LSB  = 3;

    typedef enum logic [2:0] {
        PC_SRC_HOLD,
        PC_SRC_INCR,
        PC_SRC_PCL,
        PC_SRC_JUMP,
        PC_SRC_POP
    } pc_src_e;

endpackage

// File: rtl/pc_fetch_unit_stack.sv
// Circular call/return stack: pointer, saturating fill count, sticky
// overflow/underflow flags and an uncleared entry RAM with a combinational top.
module pc_fetch_unit_stack
    import pc_fetch_unit_pkg::*;
#(
    parameter int WIDTH = PC_W,
    parameter int DEPTH = STACK_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // A pop always wins; a push issued in the same cycle is dropped.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (pop_i) begin
            ptr_d = ptr_q - PW'(1);
            if (count_q == '0) begin
                unf_d = 1'b1;
            end else begin
                count_d = count_q - (PW+1)'(1);
            end
        end else if (push_i) begin
            ptr_d = ptr_q + PW'(1);
            if (count_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries keep their contents across reset; only the write is held off while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_i && !pop_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

    assign top_o = mem_q[ptr_q - PW'(1)];
    assign ovf_o = ovf_q;
    assign unf_o = unf_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction register and return stack feeding the decoder.
// pc is a prefetch pointer: it always addresses the next instruction to fetch.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                    PC_WIDTH     = PC_W,
    parameter int                    INSTR_WIDTH  = INSTR_W,
    parameter int                    STACK_DEPTH  = STACK_D,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_rd_en,
    input  logic                   instr_flush,
    input  logic                   pc_incr_en,
    input  logic                   pc_j_en,
    input  logic                   stack_push_en,
    input  logic                   stack_pop_en,
    input  logic                   pcl_wr_en,
    input  logic [7:0]             pcl_wr_data,
    input  logic [4:0]             pclath,
    input  logic [INSTR_WIDTH-1:0] pgm_data,
    output logic [PC_WIDTH-1:0]    pgm_addr,
    output logic [INSTR_WIDTH-1:0] instr_current,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   stack_ovf,
    output logic                   stack_unf
);

    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [PC_WIDTH-1:0]    stack_top;
    pc_src_e                pc_src;

    pc_fetch_unit_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (stack_push_en),
        .pop_i       (stack_pop_en),
        .push_data_i (pc_q),
        .top_o       (stack_top),
        .ovf_o       (stack_ovf),
        .unf_o       (stack_unf)
    );

    // Only one pc update per clock: return > goto/call > computed jump > increment.
    always_comb begin
        pc_src = PC_SRC_HOLD;
        if (stack_pop_en) begin
            pc_src = PC_SRC_POP;
        end else if (pc_j_en) begin
            pc_src = PC_SRC_JUMP;
        end else if (pcl_wr_en) begin
            pc_src = PC_SRC_PCL;
        end else if (pc_incr_en) begin
            pc_src = PC_SRC_INCR;
        end

        pc_d = pc_q;
        unique case (pc_src)
            PC_SRC_POP:  pc_d = stack_top;
            PC_SRC_JUMP: pc_d = {pclath[JMP_PAGE_MSB:JMP_PAGE_LSB], ir_q[JMP_FIELD_MSB:0]};
            PC_SRC_PCL:  pc_d = {pclath, pcl_wr_data};
            PC_SRC_INCR: pc_d = pc_q + PC_WIDTH'(1);
            default:     pc_d = pc_q;
        endcase

        ir_d = ir_q;
        if (instr_flush) begin
            ir_d = ISA_NOP;
        end else if (instr_rd_en) begin
            ir_d = pgm_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
            ir_q <= ISA_NOP;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign pgm_addr      = pc_q;
    assign pc            = pc_q;
    assign instr_current = ir_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios pinned to literal
// values, then randomized strobes compared every cycle against a behavioural model.
module tb_pc_fetch_unit;

    localparam logic [6:0] S_POP  = 7'b1000000;
    localparam logic [6:0] S_PUSH = 7'b0100000;
    localparam logic [6:0] S_J    = 7'b0010000;
    localparam logic [6:0] S_PCL  = 7'b0001000;
    localparam logic [6:0] S_INC  = 7'b0000100;
    localparam logic [6:0] S_FL   = 7'b0000010;
    localparam logic [6:0] S_RD   = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en;
    logic        stack_push_en, stack_pop_en, pcl_wr_en;
    logic [7:0]  pcl_wr_data;
    logic [4:0]  pclath;
    logic [13:0] pgm_data;
    logic [12:0] pgm_addr;
    logic [13:0] instr_current;
    logic [12:0] pc;
    logic        stack_ovf, stack_unf;

    logic        useOvr;
    logic [13:0] ovrData;
    logic        checkEn;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: plain integers and an array of return addresses.
    int          mPc, mIr, mCnt, mSp;
    bit          mOvf, mUnf;
    int          mStk [8];

    pc_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_rd_en   (instr_rd_en),
        .instr_flush   (instr_flush),
        .pc_incr_en    (pc_incr_en),
        .pc_j_en       (pc_j_en),
        .stack_push_en (stack_push_en),
        .stack_pop_en  (stack_pop_en),
        .pcl_wr_en     (pcl_wr_en),
        .pcl_wr_data   (pcl_wr_data),
        .pclath        (pclath),
        .pgm_data      (pgm_data),
        .pgm_addr      (pgm_addr),
        .instr_current (instr_current),
        .pc            (pc),
        .stack_ovf     (stack_ovf),
        .stack_unf     (stack_unf)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] memHash(input logic [12:0] a);
        return {a[5:0], a[12:5]} ^ 14'h15A3;
    endfunction

    // Program memory: a fixed address hash, optionally overridden for directed words.
    assign pgm_data = useOvr ? ovrData : memHash(pgm_addr);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPc = 0; mIr = 0; mCnt = 0; mSp = 0; mOvf = 0; mUnf = 0;
    endtask

    task automatic modelStep();
        int data, nextPc;
        data   = useOvr ? int'(ovrData) : int'(memHash(13'(mPc)));
        nextPc = mPc;
        if (stack_pop_en) begin
            nextPc = mStk[(mSp - 1) & 7];
            mSp    = mSp - 1;
            if (mCnt == 0) mUnf = 1; else mCnt--;
        end else begin
            if (stack_push_en) begin
                mStk[mSp & 7] = mPc;
                mSp = mSp + 1;
                if (mCnt == 8) mOvf = 1; else mCnt++;
            end
            if (pc_j_en)         nextPc = (int'(pclath[4:3]) << 11) | (mIr & 'h7FF);
            else if (pcl_wr_en)  nextPc = (int'(pclath) << 8) | int'(pcl_wr_data);
            else if (pc_incr_en) nextPc = (mPc + 1) % 8192;
        end
        if (instr_flush)      mIr = 0;
        else if (instr_rd_en) mIr = data;
        mPc = nextPc;
    endtask

    // Drive one cycle of strobes, let the DUT take the edge, and advance the model.
    task automatic applyStimulus(input logic [6:0] s, input logic [7:0] d, input logic [4:0] lath,
                                 input bit ovr, input logic [13:0] od);
        stack_pop_en  = s[6];
        stack_push_en = s[5];
        pc_j_en       = s[4];
        pcl_wr_en     = s[3];
        pc_incr_en    = s[2];
        instr_flush   = s[1];
        instr_rd_en   = s[0];
        pcl_wr_data   = d;
        pclath        = lath;
        useOvr        = ovr;
        ovrData       = od;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic randomStep();
        logic [6:0] s;
        s = '0;
        if ($urandom_range(7) == 0) s |= S_POP;
        if ($urandom_range(5) == 0) s |= S_PUSH;
        if ($urandom_range(5) == 0) s |= S_J;
        if ($urandom_range(7) == 0) s |= S_PCL;
        if ($urandom_range(1) == 0) s |= S_INC;
        if ($urandom_range(4) == 0) s |= S_FL;
        if ($urandom_range(1) == 0) s |= S_RD;
        applyStimulus(s, 8'($urandom), 5'($urandom), 1'b0, 14'h0);
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_pc",   32'(pc),            32'(mPc));
            checkOutput("cyc_addr", 32'(pgm_addr),      32'(mPc));
            checkOutput("cyc_ir",   32'(instr_current), 32'(mIr));
            checkOutput("cyc_ovf",  32'(stack_ovf),     32'(mOvf));
            checkOutput("cyc_unf",  32'(stack_unf),     32'(mUnf));
        end
    end

    initial begin
        checkEn = 0;
        rst_n = 0;
        {instr_rd_en, instr_flush, pc_incr_en, pc_j_en} = '0;
        {stack_push_en, stack_pop_en, pcl_wr_en} = '0;
        pcl_wr_data = '0; pclath = '0; useOvr = 0; ovrData = '0;
        for (int i = 0; i < 8; i++) mStk[i] = 0;
        modelReset();
        #3;
        checkOutput("rst_pc",  32'(pc), 0);
        checkOutput("rst_ir",  32'(instr_current), 0);
        checkOutput("rst_flg", 32'({stack_ovf, stack_unf}), 0);
        #19;
        rst_n = 1;
        checkEn = 1;

        applyStimulus(S_RD | S_INC, 8'h0, 5'h0, 1'b1, 14'h3055);
        checkOutput("first_ir", 32'(instr_current), 32'h3055);
        checkOutput("first_pc", 32'(pc), 1);
        checkOutput("model_first_ir", 32'(mIr), 32'h3055);

        applyStimulus(S_PCL, 8'h05, 5'h0, 1'b0, 14'h0);
        applyStimulus(S_RD, 8'h0, 5'h0, 1'b1, 14'h2923);
        applyStimulus(S_FL | S_J, 8'h0, 5'b01000, 1'b0, 14'h0);
        checkOutput("goto_pc", 32'(pc), 32'h923);
        checkOutput("goto_ir", 32'(instr_current), 0);
        checkOutput("model_goto_pc", 32'(mPc), 32'h923);
        applyStimulus(S_RD, 8'h0, 5'h0, 1'b0, 14'h0);
        checkOutput("goto_fetch", 32'(instr_current), 32'(memHash(13'h923)));

        applyStimulus(S_PCL, 8'd10, 5'h0, 1'b0, 14'h0);
        applyStimulus(S_FL | S_INC | S_RD, 8'h0, 5'h0, 1'b1, 14'h0ABC);
        checkOutput("skip_pc", 32'(pc), 11);
        checkOutput("skip_ir", 32'(instr_current), 0);

        applyStimulus(S_PCL, 8'h40, 5'h0, 1'b0, 14'h0);
        applyStimulus(S_RD, 8'h0, 5'h0, 1'b1, 14'h2200);
        applyStimulus(S_PUSH | S_J, 8'h0, 5'h0, 1'b0, 14'h0);
        checkOutput("call_pc", 32'(pc), 32'h200);
        applyStimulus(S_POP | S_FL, 8'h0, 5'h0, 1'b0, 14'h0);
        checkOutput("ret_pc", 32'(pc), 32'h40);
        checkOutput("ret_ir", 32'(instr_current), 0);

        applyStimulus(S_PCL, 8'd1, 5'h0, 1'b0, 14'h0);
        for (int k = 2; k <= 10; k++) begin
            applyStimulus(S_PUSH | S_PCL, 8'(k), 5'h0, 1'b0, 14'h0);
            if (k == 9) checkOutput("ovf_at8", 32'(stack_ovf), 0);
        end
        checkOutput("ovf_at9", 32'(stack_ovf), 1);
        checkOutput("model_ovf", 32'(mOvf), 1);
        for (int k = 9; k >= 2; k--) begin
            applyStimulus(S_POP, 8'h0, 5'h0, 1'b0, 14'h0);
            checkOutput("pop_val", 32'(pc), 32'(k));
        end
        checkOutput("unf_before", 32'(stack_unf), 0);
        applyStimulus(S_POP, 8'h0, 5'h0, 1'b0, 14'h0);
        checkOutput("unf_after", 32'(stack_unf), 1);
        checkOutput("unf_pc", 32'(pc), 9);

        applyStimulus(S_PCL, 8'h77, 5'h0, 1'b0, 14'h0);
        applyStimulus(S_PUSH, 8'h0, 5'h0, 1'b0, 14'h0);
        applyStimulus(S_POP | S_J | S_INC, 8'h0, 5'h1F, 1'b0, 14'h0);
        checkOutput("prio_pc", 32'(pc), 32'h77);

        applyStimulus(S_PCL, 8'hFF, 5'h1F, 1'b0, 14'h0);
        applyStimulus(S_INC, 8'h0, 5'h0, 1'b0, 14'h0);
        checkOutput("wrap_pc", 32'(pc), 0);

        for (int n = 0; n < 400; n++) randomStep();

        stack_push_en = 1; pc_incr_en = 1; instr_rd_en = 1;
        #3;
        rst_n = 0;
        modelReset();
        #1;
        checkOutput("arst_pc",  32'(pc), 0);
        checkOutput("arst_ir",  32'(instr_current), 0);
        checkOutput("arst_flg", 32'({stack_ovf, stack_unf}), 0);
        @(negedge clk);
        #2;
        rst_n = 1;
        for (int n = 0; n < 60; n++) randomStep();

        @(negedge clk);
        checkEn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
